// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BREX    = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Per-state control word; ir_req/pc_write in FETCH still need mem_ready.
    typedef struct packed {
        logic       i_or_d;
        logic       ir_req;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

    // Moore output table: the control word each state drives.
    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_req    = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            DECODE:  c.alu_src_b = 2'b11;
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD: begin
                c.i_or_d   = 1'b1;
                c.mem_read = 1'b1;
            end
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            MEMWR: begin
                c.i_or_d    = 1'b1;
                c.mem_write = 1'b1;
            end
            RTYPEEX: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            BREX: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_SUB;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
            ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ADDIWB:  c.reg_write = 1'b1;
            JEX: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_alu_op_decoder.sv
// Second-level ALU decode: ALUOp plus funct field to ALU control code.
module alu_op_decoder
    import multicycle_control_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       funct_illegal
);

    // Unknown funct falls back to add and is flagged so the FSM can report it.
    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with mem_ready handshake and ALU decode.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int ENABLE_BNE  = 1,
    parameter int ENABLE_JUMP = 1,
    parameter int MEM_WAIT    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [3:0] alu_control,
    output logic [3:0] state,
    output logic       illegal_op
);

    state_t state_q;
    state_t next_state;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_eff;
    logic   mem_ok;
    logic   decode_illegal;
    logic   funct_illegal;
    logic   beq_cond;
    logic   bne_cond;
    logic   pc_write_eff;

    assign mem_ok = (MEM_WAIT == 0) ? 1'b1 : mem_ready;

    // Next-state selection, including opcode decode and the memory wait holds.
    always_comb begin
        next_state     = state_q;
        decode_illegal = 1'b0;
        case (state_q)
            FETCH:   if (mem_ok) next_state = DECODE;
            DECODE: begin
                next_state = FETCH;
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = RTYPEEX;
                    OP_BEQ:       next_state = BREX;
                    OP_BNE: begin
                        if (ENABLE_BNE != 0) next_state = BREX;
                        else                 decode_illegal = 1'b1;
                    end
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J: begin
                        if (ENABLE_JUMP != 0) next_state = JEX;
                        else                  decode_illegal = 1'b1;
                    end
                    default:      decode_illegal = 1'b1;
                endcase
            end
            MEMADR:  next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (mem_ok) next_state = MEMWB;
            MEMWB:   next_state = FETCH;
            MEMWR:   if (mem_ok) next_state = FETCH;
            RTYPEEX: next_state = RTYPEWB;
            RTYPEWB: next_state = FETCH;
            BREX:    next_state = FETCH;
            ADDIEX:  next_state = ADDIWB;
            ADDIWB:  next_state = FETCH;
            JEX:     next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // State register with the control word registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= state_ctrl(FETCH);
        end else begin
            state_q <= next_state;
            ctrl_q  <= state_ctrl(next_state);
        end
    end

    // Reset silences every strobe immediately, aborting any pending access.
    assign ctrl_eff = reset ? ctrl_t'('0) : ctrl_q;

    alu_op_decoder u_alu_op_decoder (
        .alu_op        (ctrl_eff.alu_op),
        .funct         (funct),
        .alu_control   (alu_control),
        .funct_illegal (funct_illegal)
    );

    assign beq_cond     = ctrl_eff.branch & (opcode == OP_BEQ);
    assign bne_cond     = ctrl_eff.branch & (opcode == OP_BNE);
    assign pc_write_eff = ctrl_eff.pc_write & (~ctrl_eff.ir_req | mem_ok);

    assign pc_en      = pc_write_eff | (beq_cond & zero) | (bne_cond & ~zero);
    assign ir_write   = ctrl_eff.ir_req & mem_ok;
    assign i_or_d     = ctrl_eff.i_or_d;
    assign mem_read   = ctrl_eff.mem_read;
    assign mem_write  = ctrl_eff.mem_write;
    assign reg_write  = ctrl_eff.reg_write;
    assign reg_dst    = ctrl_eff.reg_dst;
    assign mem_to_reg = ctrl_eff.mem_to_reg;
    assign alu_src_a  = ctrl_eff.alu_src_a;
    assign alu_src_b  = ctrl_eff.alu_src_b;
    assign pc_src     = ctrl_eff.pc_src;
    assign state      = state_q;
    assign illegal_op = ~reset & (decode_illegal | funct_illegal);

endmodule
